// File: rtl/jt89_mix_pkg.sv
// Shared definitions for the jt89 channel mixer: FSM encoding, unity gain
// code and the accumulator sizing rule used by the top level.
package jt89_mix_pkg;

    // Frame sequencing: snapshot inputs, accumulate one channel per step, publish
    typedef enum logic [1:0] {
        ST_LATCH = 2'd0,
        ST_ACC   = 2'd1,
        ST_OUT   = 2'd2
    } mix_state_e;

    // Gain code 3 maps to a scale of 2^0
    localparam logic [2:0] GAIN_UNITY = 3'd3;

    // Each term grows by at most 4 bits (gain x16), summing CH terms adds
    // log2(CH) bits, and one guard bit keeps the running sum from wrapping.
    function automatic int mix_acc_width(input int iw, input int ch);
        return iw + 4 + $clog2(ch) + 1;
    endfunction

endpackage

// File: rtl/jt89_mix_sat.sv
// Signed clamp from the wide mixer accumulator down to the output word.
// Purely combinational; clip_o marks a sample that had to be limited.
module jt89_mix_sat #(
    parameter int AW = 17,
    parameter int OW = 12
) (
    input  logic signed [AW-1:0] acc_i,
    output logic signed [OW-1:0] sat_o,
    output logic                 clip_o
);

    // Largest and smallest values representable in OW signed bits, at AW width
    localparam logic signed [AW-1:0] MAX_V = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_V = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    // Pass the value through when it fits, otherwise pin it to the nearest rail
    always_comb begin
        sat_o  = acc_i[OW-1:0];
        clip_o = 1'b0;
        if (acc_i > MAX_V) begin
            sat_o  = MAX_V[OW-1:0];
            clip_o = 1'b1;
        end else if (acc_i < MIN_V) begin
            sat_o  = MIN_V[OW-1:0];
            clip_o = 1'b1;
        end
    end

endmodule

// File: rtl/jt89_mixn.sv
// Time-multiplexed signed mixer for the jt89 sound path. Each frame takes a
// snapshot of every channel and its gain, accumulates one scaled channel per
// enabled cycle, then clamps the sum onto the output word with a sticky
// overflow flag. Gain writes go to a live register file that is only sampled
// at the start of a frame, so a frame never sees a half-updated gain set.
module jt89_mixn
    import jt89_mix_pkg::*;
#(
    parameter int CH = 4,
    parameter int IW = 10,
    parameter int OW = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic [CH*IW-1:0]        ch_in,
    input  logic                    gain_wr,
    input  logic [$clog2(CH)-1:0]   gain_ch,
    input  logic [2:0]              gain_din,
    input  logic                    ov_clr,
    output logic signed [OW-1:0]    sound,
    output logic                    sound_vld,
    output logic                    ov
);

    localparam int AW  = mix_acc_width(IW, CH);
    // The shift is evaluated three bits wider than the accumulator so that a
    // left shift by up to 7 can never drop bits before the >>> 3 brings it back
    localparam int TW  = AW + 3;
    localparam int IXW = $clog2(CH);

    mix_state_e            state_q;
    logic [IXW-1:0]        idx_q;
    logic signed [AW-1:0]  acc_q;
    logic signed [AW-1:0]  acc_d;
    logic signed [IW-1:0]  snap_q  [CH];
    logic [2:0]            gsnap_q [CH];
    logic [2:0]            gain_q  [CH];
    logic signed [OW-1:0]  sound_q;
    logic                  vld_q;
    logic                  ov_q;

    logic signed [IW-1:0]  cur_x;
    logic [2:0]            cur_g;
    logic signed [TW-1:0]  x_ext;
    logic signed [AW-1:0]  term_d;
    logic signed [OW-1:0]  sat_w;
    logic                  clip_w;

    // Scale the currently indexed snapshot: (x <<< g) >>> 3, flooring toward -inf
    always_comb begin
        cur_x  = snap_q[idx_q];
        cur_g  = gsnap_q[idx_q];
        x_ext  = {{(TW-IW){cur_x[IW-1]}}, cur_x};
        term_d = AW'((x_ext <<< cur_g) >>> 3);
        acc_d  = acc_q + term_d;
    end

    jt89_mix_sat #(
        .AW (AW),
        .OW (OW)
    ) u_sat (
        .acc_i  (acc_q),
        .sat_o  (sat_w),
        .clip_o (clip_w)
    );

    // Live gain register file; writes land whenever strobed, regardless of the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CH; k++) begin
                gain_q[k] <= GAIN_UNITY;
            end
        end else if (gain_wr) begin
            for (int k = 0; k < CH; k++) begin
                if (gain_ch == IXW'(k)) begin
                    gain_q[k] <= gain_din;
                end
            end
        end
    end

    // Frame sequencer: snapshot, accumulate, then publish the clamped sample
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LATCH;
            idx_q   <= '0;
            acc_q   <= '0;
            sound_q <= '0;
            vld_q   <= 1'b0;
            ov_q    <= 1'b0;
            for (int k = 0; k < CH; k++) begin
                snap_q[k]  <= '0;
                gsnap_q[k] <= GAIN_UNITY;
            end
        end else begin
            vld_q <= 1'b0;
            if (ov_clr) begin
                ov_q <= 1'b0;
            end
            if (clk_en) begin
                unique case (state_q)
                    ST_LATCH: begin
                        for (int k = 0; k < CH; k++) begin
                            snap_q[k]  <= ch_in[k*IW +: IW];
                            gsnap_q[k] <= gain_q[k];
                        end
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= ST_ACC;
                    end
                    ST_ACC: begin
                        acc_q <= acc_d;
                        if (idx_q == IXW'(CH-1)) begin
                            idx_q   <= '0;
                            state_q <= ST_OUT;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                    ST_OUT: begin
                        sound_q <= sat_w;
                        vld_q   <= 1'b1;
                        if (clip_w) begin
                            ov_q <= 1'b1;
                        end
                        state_q <= ST_LATCH;
                    end
                    default: begin
                        state_q <= ST_LATCH;
                    end
                endcase
            end
        end
    end

    assign sound     = sound_q;
    assign sound_vld = vld_q;
    assign ov        = ov_q;

endmodule
